// File: rtl/uart_pkg.sv
// Shared UART definitions: frame shape, receiver states and small helpers
// used by the receiver today and a transmitter later.
package uart_pkg;

  localparam int       DATA_BITS        = 8;
  localparam logic     PARITY_ODD       = 1'b1;
  localparam int       CLKS_PER_BIT_DEF = 128;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  // True when data ones plus the parity bit give the selected parity sense.
  function automatic logic parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
    return (^{d, p}) == PARITY_ODD;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO; full/empty come from the occupancy count.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A pop frees the slot in the same cycle, so push+pop succeeds even when full.
  assign push_ok = push & (~full | pop_ok);
  assign ovf     = push & full & ~pop;
  assign data    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8 data bits, odd parity, 1 stop) feeding a byte FIFO.
// Consumers treat !empty as valid and rd_en as ready; a byte moves when both are high.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          RX,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  input  logic                          clr_err,
  output logic                          par_err,
  output logic                          stp_err,
  output logic                          ovf_err,
  output logic                          brk_det,
  output logic [2:0]                    dbg_state
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] S0   = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] S1   = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] S2   = 16'(CLKS_PER_BIT / 2 + 1);

  rx_state_t            state;
  logic                 rx_meta, rxs, rxs_d;
  logic [2:0]           arm;
  logic [15:0]          cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, smp0, smp1;
  logic                 decide, maj, fall;
  logic                 push_req, par_ev, stp_ev, brk_ev, ovf_ev;
  logic                 push_q;
  logic [7:0]           push_byte;

  // arm keeps the reset value of the synchronizer from looking like a start edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
      arm     <= '0;
    end else begin
      rx_meta <= RX;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
      arm     <= {arm[1:0], 1'b1};
    end
  end

  assign fall      = arm[2] & rxs_d & ~rxs;
  assign decide    = (cnt == S2);
  assign maj       = (smp0 & smp1) | (smp0 & rxs) | (smp1 & rxs);
  assign dbg_state = state;

  always_comb begin
    push_req = 1'b0;
    par_ev   = 1'b0;
    stp_ev   = 1'b0;
    brk_ev   = 1'b0;
    if (state == ST_STOP && decide) begin
      if (maj) begin
        if (parity_ok(shreg, par_bit)) push_req = 1'b1;
        else                           par_ev   = 1'b1;
      end else if ({shreg, par_bit} == '0) begin
        brk_ev = 1'b1;
      end else begin
        stp_ev = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      smp0    <= 1'b0;
      smp1    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (fall) state <= ST_START;
        end
        ST_BREAK: begin
          if (!rxs) cnt <= '0;
          else if (cnt == LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else cnt <= cnt + 16'd1;
        end
        default: begin
          // State names the bit being sampled; the decision at S2 picks the next one.
          cnt <= (cnt == LAST) ? 16'd0 : cnt + 16'd1;
          if (cnt == S0) smp0 <= rxs;
          if (cnt == S1) smp1 <= rxs;
          if (decide) begin
            case (state)
              ST_START: begin
                bit_idx <= '0;
                state   <= maj ? ST_IDLE : ST_DATA;
              end
              ST_DATA: begin
                shreg   <= {maj, shreg[DATA_BITS-1:1]};
                bit_idx <= bit_idx + 3'd1;
                if (bit_idx == 3'(DATA_BITS - 1)) state <= ST_PARITY;
              end
              ST_PARITY: begin
                par_bit <= maj;
                state   <= ST_STOP;
              end
              ST_STOP: begin
                cnt   <= '0;
                state <= maj ? ST_IDLE : ST_BREAK;
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      push_q    <= 1'b0;
      push_byte <= '0;
    end else begin
      push_q    <= push_req;
      push_byte <= shreg;
    end
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .push      (push_q),
    .push_data (push_byte),
    .pop       (rd_en),
    .data      (rd_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf_ev)
  );

  // An error event in the same cycle as clr_err keeps its flag set.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      par_err <= 1'b0;
      stp_err <= 1'b0;
      ovf_err <= 1'b0;
      brk_det <= 1'b0;
    end else begin
      par_err <= par_ev | (par_err & ~clr_err);
      stp_err <= stp_ev | (stp_err & ~clr_err);
      ovf_err <= ovf_ev | (ovf_err & ~clr_err);
      brk_det <= brk_ev | (brk_det & ~clr_err);
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Random and directed UART frames against a frame-level model; a monitor pops
// the FIFO and checks each byte against the expected queue.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       Clk;
  logic       Rst_n;
  logic       RX;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       empty, full;
  logic [2:0] count;
  logic       par_err, stp_err, ovf_err, brk_det;
  logic [2:0] dbg_state;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .RX        (RX),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .clr_err   (clr_err),
    .par_err   (par_err),
    .stp_err   (stp_err),
    .ovf_err   (ovf_err),
    .brk_det   (brk_det),
    .dbg_state (dbg_state)
  );

  // clock/reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       consumer_on = 1'b0;
  logic       m_par = 0, m_stp = 0, m_ovf = 0, m_brk = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return ~(^d);
  endfunction

  // driver tasks
  task automatic drive_bit(input logic v, input int cycles);
    @(negedge Clk);
    RX = v;
    repeat (cycles - 1) @(negedge Clk);
  endtask

  // Model: a well-formed frame lands in the FIFO unless the FIFO is full and
  // nobody is reading; a bad frame only raises its flag.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stp);
    if (stp) begin
      if ((($countones(d) + int'(p)) % 2) == 1) begin
        if (!consumer_on && exp_q.size() >= DEPTH) m_ovf = 1'b1;
        else exp_q.push_back(d);
      end else m_par = 1'b1;
    end else if (d == 8'h00 && !p) m_brk = 1'b1;
    else m_stp = 1'b1;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
    drive_bit(p, CPB);
    drive_bit(stp, CPB);
    drive_bit(1'b1, 2 * CPB);
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_par_err"}, int'(par_err), int'(m_par));
    chk({tag, "_stp_err"}, int'(stp_err), int'(m_stp));
    chk({tag, "_ovf_err"}, int'(ovf_err), int'(m_ovf));
    chk({tag, "_brk_det"}, int'(brk_det), int'(m_brk));
  endtask

  task automatic clear_flags();
    @(negedge Clk) clr_err = 1'b1;
    @(negedge Clk) clr_err = 1'b0;
    m_par = 0; m_stp = 0; m_ovf = 0; m_brk = 0;
    @(negedge Clk);
    check_flags("clr");
  endtask

  task automatic drain(input string tag);
    consumer_on = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge Clk);
    chk({tag, "_drained"}, exp_q.size(), 0);
    repeat (3) @(negedge Clk);
    chk({tag, "_empty"}, int'(empty), 1);
  endtask

  // scoreboard monitor: pops whenever the FIFO presents a byte
  initial begin
    rd_en = 1'b0;
    forever begin
      @(negedge Clk);
      if (rd_en) rd_en = 1'b0;
      else if (consumer_on && Rst_n && !empty) begin
        if (exp_q.size() == 0) chk("unexpected_byte", int'(rd_data), -1);
        else chk("rd_data", int'(rd_data), int'(exp_q.pop_front()));
        rd_en = 1'b1;
      end
    end
  end

  initial begin
    int         lat;
    logic [7:0] d;
    logic       p, s;
    RX = 1'b1; clr_err = 1'b0; Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_state", int'(dbg_state), 0);
    check_flags("rst");
    Rst_n = 1'b1;
    repeat (4 * CPB) @(negedge Clk);

    // 0xA5 with good parity; measure start edge to empty falling
    lat = -1;
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        @(negedge Clk);
        for (int i = 1; i < 20 * CPB && lat < 0; i++) begin
          @(negedge Clk);
          if (!empty) lat = i;
        end
      end
    join
    chk("a5_latency_seen", int'(lat >= 0), 1);
    chk("a5_latency_range", int'(lat >= 10 * CPB + CPB / 2 && lat <= 11 * CPB + 8), 1);
    chk("a5_count", int'(count), 1);
    check_flags("a5");
    drain("a5");

    // 0x55 with bad parity
    send_frame(8'h55, 1'b0, 1'b1);
    chk("par_empty", int'(empty), 1);
    check_flags("par");
    clear_flags();

    // overflow: five bytes, nobody reading
    consumer_on = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), good_par(8'(i)), 1'b1);
    chk("ovf_full", int'(full), 1);
    chk("ovf_count", int'(count), DEPTH);
    check_flags("ovf");
    drain("ovf");
    clear_flags();

    // break: line low for 20 bit times, then a normal byte
    m_brk = 1'b1;
    drive_bit(1'b0, 20 * CPB);
    drive_bit(1'b1, 2 * CPB);
    chk("brk_empty", int'(empty), 1);
    check_flags("brk");
    clear_flags();
    send_frame(8'h3C, good_par(8'h3C), 1'b1);
    drain("brk_3c");

    // short glitch on idle line
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 2 * CPB);
    chk("glitch_state", int'(dbg_state), 0);
    chk("glitch_empty", int'(empty), 1);
    check_flags("glitch");

    // stop-bit error
    send_frame(8'h81, good_par(8'h81), 1'b0);
    check_flags("stp");
    clear_flags();

    // reset in the middle of 0x77 with a byte already waiting
    consumer_on = 1'b0;
    send_frame(8'h66, good_par(8'h66), 1'b1);
    chk("pre_rst_count", int'(count), 1);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 3; i++) drive_bit(1'(8'h77 >> i), CPB);
    @(negedge Clk) Rst_n = 1'b0;
    exp_q.delete();
    RX = 1'b1;
    @(negedge Clk);
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_rd_data", int'(rd_data), 0);
    chk("mid_rst_state", int'(dbg_state), 0);
    @(negedge Clk) Rst_n = 1'b1;
    drive_bit(1'b1, 2 * CPB);
    send_frame(8'h12, good_par(8'h12), 1'b1);
    chk("post_rst_count", int'(count), 1);
    drain("post_rst");

    // random frames with occasional parity and stop errors
    for (int n = 0; n < 16; n++) begin
      d = 8'($urandom_range(0, 255));
      p = ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d);
      s = ($urandom_range(0, 7) != 0);
      send_frame(d, p, s);
      check_flags("rand");
      if (m_par || m_stp || m_brk || m_ovf) clear_flags();
    end
    drain("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
